// File: rtl/ex_stage_mul.sv
// rtl/ex_stage_mul.sv - execute stage: forwarding, ALU, RegDst and iterative shift-add multiplier
module ex_stage_mul #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic             kill_i,
    input  logic             alusrc_i,
    input  logic [1:0]       aluop_i,
    input  logic             regdst_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [4:0]       rt_i,
    input  logic [4:0]       rd_i,
    input  logic [1:0]       fwd_a_i,
    input  logic [1:0]       fwd_b_i,
    input  logic [WIDTH-1:0] exmem_data_i,
    input  logic [WIDTH-1:0] memwb_data_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] store_data_o,
    output logic [4:0]       write_reg_o,
    output logic             stall_o,
    output logic             mul_busy_o
);

    localparam int CW = $clog2(MUL_STEPS) + 1;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_ctrl_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic [5:0]       funct;
    alu_ctrl_t        alu_ctrl;
    logic             is_mul;
    logic             stall_c;
    logic             busy_c;

    assign funct = imm_i[5:0];

    // Operand A forwarding mux (11 falls back to the register file value)
    always_comb begin
        op_a = rs_data_i;
        case (fwd_a_i)
            2'b10:   op_a = exmem_data_i;
            2'b01:   op_a = memwb_data_i;
            default: op_a = rs_data_i;
        endcase
    end

    // Operand B forwarding mux; the forwarded value also serves as store data
    always_comb begin
        fwd_b = rt_data_i;
        case (fwd_b_i)
            2'b10:   fwd_b = exmem_data_i;
            2'b01:   fwd_b = memwb_data_i;
            default: fwd_b = rt_data_i;
        endcase
    end

    assign op_b         = alusrc_i ? imm_i : fwd_b;
    assign store_data_o = fwd_b;
    assign write_reg_o  = regdst_i ? rd_i : rt_i;

    // ALU control decode; unknown functs and the mul funct fall back to add
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (aluop_i)
            2'b01: alu_ctrl = ALU_SUB;
            2'b10: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    // Single-cycle ALU, add/sub wrap silently
    always_comb begin
        alu_result = op_a + op_b;
        case (alu_ctrl)
            ALU_SUB: alu_result = op_a - op_b;
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            default: alu_result = op_a + op_b;
        endcase
    end

    assign is_mul = valid_i & (aluop_i == 2'b10) & (funct == FUNCT_MUL) & ~kill_i;

    // Multiplier FSM next-state, datapath step and output selection
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        stall_c  = 1'b0;
        busy_c   = 1'b0;
        result_o = alu_result;
        case (state_q)
            S_IDLE: begin
                stall_c = is_mul;
                if (is_mul) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                busy_c = 1'b1;
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    stall_c  = 1'b1;
                    acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(MUL_STEPS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                result_o = acc_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stall is masked while reset is held so an in-flight MUL releases the pipe immediately
    assign stall_o    = stall_c & rst_n_i;
    assign mul_busy_o = busy_c;

    // Multiplier state and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_mul.sv
// tb/tb_ex_stage_mul.sv - randomized self-checking bench for ex_stage_mul
module tb_ex_stage_mul;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        kill_i;
    logic        alusrc_i;
    logic [1:0]  aluop_i;
    logic        regdst_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [1:0]  fwd_a_i;
    logic [1:0]  fwd_b_i;
    logic [31:0] exmem_data_i;
    logic [31:0] memwb_data_i;
    logic [31:0] result_o;
    logic [31:0] store_data_o;
    logic [4:0]  write_reg_o;
    logic        stall_o;
    logic        mul_busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    ex_stage_mul #(.WIDTH(32), .MUL_STEPS(32)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .kill_i       (kill_i),
        .alusrc_i     (alusrc_i),
        .aluop_i      (aluop_i),
        .regdst_i     (regdst_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_i        (imm_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .fwd_a_i      (fwd_a_i),
        .fwd_b_i      (fwd_b_i),
        .exmem_data_i (exmem_data_i),
        .memwb_data_i (memwb_data_i),
        .result_o     (result_o),
        .store_data_o (store_data_o),
        .write_reg_o  (write_reg_o),
        .stall_o      (stall_o),
        .mul_busy_o   (mul_busy_o)
    );

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                            input logic [31:0] ex_v, input logic [31:0] wb_v);
        if (sel == 2'b10) return ex_v;
        if (sel == 2'b01) return wb_v;
        return reg_v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [5:0] fn);
        if (op == 2'b01) return a - b;
        if (op == 2'b10) begin
            if (fn == 6'h22) return a - b;
            if (fn == 6'h24) return a & b;
            if (fn == 6'h25) return a | b;
        end
        return a + b;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_bubble();
        valid_i = 1'b0; kill_i = 1'b0; alusrc_i = 1'b0; aluop_i = 2'b00; regdst_i = 1'b0;
        rs_data_i = 0; rt_data_i = 0; imm_i = 0; rt_i = 0; rd_i = 0;
        fwd_a_i = 0; fwd_b_i = 0; exmem_data_i = 0; memwb_data_i = 0;
    endtask

    task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
        set_bubble();
        valid_i = 1'b1; aluop_i = 2'b10; imm_i = 32'h0000_0018;
        rs_data_i = a; rt_data_i = b; rd_i = 5'd3; regdst_i = 1'b1;
    endtask

    // Runs one MUL from IDLE and checks the 33-cycle stall and the DONE result.
    // Ends one cycle after DONE with the FSM in IDLE and the pipe holding a bubble.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string name);
        int n;
        logic [31:0] exp;
        exp = a * b;
        set_mul(a, b);
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n !== 33) begin
            bad++; $display("FAIL %s stall_len got=%0d exp=33", name, n);
        end
        total++;
        if (stall_o !== 1'b0 || mul_busy_o !== 1'b0 || result_o !== exp) begin
            bad++;
            $display("FAIL %s done got stall=%b busy=%b result=%h exp stall=0 busy=0 result=%h",
                     name, stall_o, mul_busy_o, result_o, exp);
        end
        step();
        total++;
        if (stall_o !== 1'b1 || mul_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after_done got stall=%b busy=%b exp stall=1 busy=0",
                     name, stall_o, mul_busy_o);
        end
        set_bubble();
        #1;
        total++;
        if (stall_o !== 1'b0 || mul_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_bubble got stall=%b busy=%b exp 0/0", name, stall_o, mul_busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'($urandom); kill_i = 1'($urandom); alusrc_i = 1'($urandom);
            aluop_i = 2'($urandom); regdst_i = 1'($urandom);
            rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
            rt_i = 5'($urandom); rd_i = 5'($urandom);
            fwd_a_i = 2'($urandom); fwd_b_i = 2'($urandom);
            exmem_data_i = $urandom; memwb_data_i = $urandom;
            step();
            total++;
            if (stall_o !== 1'b0 || mul_busy_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs got stall=%b busy=%b exp 0/0", stall_o, mul_busy_o);
            end
        end
        set_bubble();
        step();
        rst_n_i = 1'b1;
        step();
        valid_i = 1'b1; rs_data_i = 5; imm_i = 7; alusrc_i = 1'b1; aluop_i = 2'b00;
        rt_i = 5'd17; rd_i = 5'd4; regdst_i = 1'b0;
        #1;
        total++;
        if (result_o !== 32'd12 || write_reg_o !== 5'd17) begin
            bad++;
            $display("FAIL reset_addi got result=%0d wreg=%0d exp result=12 wreg=17",
                     result_o, write_reg_o);
        end
        step();
    endtask

    task automatic test_rtype();
        set_bubble();
        valid_i = 1'b1; aluop_i = 2'b10; imm_i = 32'h22;
        rs_data_i = 3; rt_data_i = 10; fwd_a_i = 2'b10; exmem_data_i = 20;
        #1;
        total++;
        if (result_o !== 32'd10) begin
            bad++; $display("FAIL rtype_sub got=%0d exp=10", result_o);
        end
        fwd_a_i = 2'b00; rs_data_i = 32'hF0F0; rt_data_i = 32'h0FF0; imm_i = 32'h24;
        #1;
        total++;
        if (result_o !== 32'h00F0) begin
            bad++; $display("FAIL rtype_and got=%h exp=000000f0", result_o);
        end
        imm_i = 32'h25; regdst_i = 1'b1; rd_i = 5'd9; rt_i = 5'd2;
        #1;
        total++;
        if (result_o !== 32'hFFF0 || write_reg_o !== 5'd9) begin
            bad++;
            $display("FAIL rtype_or got result=%h wreg=%0d exp result=0000fff0 wreg=9",
                     result_o, write_reg_o);
        end
        step();
    endtask

    task automatic test_alu_random();
        logic [5:0] fn_tab [5];
        logic [31:0] a, fb, b, exp;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25; fn_tab[4] = 6'h18;
        for (int i = 0; i < 40; i++) begin
            valid_i = 1'($urandom); kill_i = 1'($urandom); alusrc_i = 1'($urandom);
            aluop_i = 2'($urandom); regdst_i = 1'($urandom);
            rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
            if ($urandom_range(0, 1) == 0) imm_i[5:0] = fn_tab[$urandom_range(0, 4)];
            rt_i = 5'($urandom); rd_i = 5'($urandom);
            fwd_a_i = 2'($urandom); fwd_b_i = 2'($urandom);
            exmem_data_i = $urandom; memwb_data_i = $urandom;
            if (valid_i && aluop_i == 2'b10 && imm_i[5:0] == 6'h18) kill_i = 1'b1;
            #1;
            a   = ref_fwd(fwd_a_i, rs_data_i, exmem_data_i, memwb_data_i);
            fb  = ref_fwd(fwd_b_i, rt_data_i, exmem_data_i, memwb_data_i);
            b   = alusrc_i ? imm_i : fb;
            exp = ref_alu(aluop_i, a, b, imm_i[5:0]);
            total++;
            if (result_o !== exp || store_data_o !== fb || stall_o !== 1'b0 ||
                write_reg_o !== (regdst_i ? rd_i : rt_i)) begin
                bad++;
                $display("FAIL alu_rand[%0d] got res=%h sd=%h wr=%0d st=%b exp res=%h sd=%h wr=%0d st=0",
                         i, result_o, store_data_o, write_reg_o, stall_o, exp, fb,
                         regdst_i ? rd_i : rt_i);
            end
            step();
        end
        set_bubble();
    endtask

    task automatic test_mul_basic();
        run_mul(32'd7, 32'd6, "mul_7x6");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
        run_mul(32'h8000_0000, 32'd2, "mul_wrap");
        for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, "mul_rand");
    endtask

    task automatic test_back_to_back();
        run_mul(32'd3, 32'd4, "b2b_first");
        run_mul(32'd5, 32'd5, "b2b_second");
    endtask

    task automatic test_kill();
        set_mul(32'd9, 32'd9);
        step();
        for (int i = 0; i < 10; i++) step();
        kill_i = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b0 || mul_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL kill_cycle got stall=%b busy=%b exp stall=0 busy=1", stall_o, mul_busy_o);
        end
        step();
        set_bubble();
        #1;
        total++;
        if (stall_o !== 1'b0 || mul_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL kill_next got stall=%b busy=%b exp 0/0", stall_o, mul_busy_o);
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        set_mul(32'd11, 32'd13);
        step();
        for (int i = 0; i < 5; i++) step();
        total++;
        if (stall_o !== 1'b1 || mul_busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got stall=%b busy=%b exp 1/1", stall_o, mul_busy_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0 || mul_busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got stall=%b busy=%b exp 0/0", stall_o, mul_busy_o);
        end
        set_bubble();
        step();
        rst_n_i = 1'b1;
        step();
        run_mul(32'd11, 32'd13, "mul_after_reset");
    endtask

    initial begin
        set_bubble();
        rst_n_i = 1'b0;
        test_reset();
        test_rtype();
        test_alu_random();
        test_mul_basic();
        test_back_to_back();
        test_kill();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
